// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave with TX/RX FIFOs, input synchronizers and sticky error flags.
module spi_slave #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CS_n,
  input  logic             SCK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] TXdata,
  input  logic             writeEn,
  output logic             TXFIFOempty,
  output logic             TXFIFOfull,
  output logic [WIDTH-1:0] RXdata,
  input  logic             readEn,
  output logic             RXFIFOempty,
  output logic             RXFIFOfull,
  output logic             wordDone,
  output logic             doneTransaction,
  output logic             overrun,
  output logic             underrun,
  input  logic             clearErr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, nextState;
  logic [1:0] csSync, sckSync, mosiSync;
  logic csPrev, sckPrev, csFall, csRise, sckRise, sckFall, active;
  logic [WIDTH-1:0] txShift, rxShift;
  logic [CW-1:0] bitCnt;
  logic reloadPend, wrapRise;
  logic [WIDTH-1:0] txMem [DEPTH];
  logic [WIDTH-1:0] rxMem [DEPTH];
  logic [AW:0] txWp, txRp, rxWp, rxRp;
  logic txLoad, txPop, txPush, rxPop, rxPush;
  // CS_n synchronizer resets low so a select held across reset is not seen as a fresh falling edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      csSync <= '0;
      sckSync <= '0;
      mosiSync <= '0;
      csPrev <= 1'b0;
      sckPrev <= 1'b0;
    end else begin
      csSync <= {csSync[0], CS_n};
      sckSync <= {sckSync[0], SCK};
      mosiSync <= {mosiSync[0], MOSI};
      csPrev <= csSync[1];
      sckPrev <= sckSync[1];
    end
  assign csFall = csPrev & ~csSync[1];
  assign csRise = ~csPrev & csSync[1];
  assign sckRise = ~sckPrev & sckSync[1];
  assign sckFall = sckPrev & ~sckSync[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nextState;
  always_comb
    nextState = state == IDLE ? (csFall ? ACTIVE : IDLE) : (csRise ? IDLE : ACTIVE);
  always_comb begin
    active = state == ACTIVE;
    MISO = active & txShift[WIDTH-1];
  end
  assign TXFIFOempty = txWp == txRp;
  assign TXFIFOfull = txWp == {~txRp[AW], txRp[AW-1:0]};
  assign RXFIFOempty = rxWp == rxRp;
  assign RXFIFOfull = rxWp == {~rxRp[AW], rxRp[AW-1:0]};
  assign wrapRise = active & sckRise & ~csRise & (bitCnt == CW'(WIDTH - 1));
  assign txLoad = (state == IDLE & csFall) | (active & sckFall & reloadPend);
  assign txPop = txLoad & ~TXFIFOempty;
  assign txPush = writeEn & (~TXFIFOfull | txPop);
  assign rxPop = readEn & ~RXFIFOempty;
  assign rxPush = wordDone & (~RXFIFOfull | rxPop);
  always_ff @(posedge clk) begin
    if (txPush) txMem[txWp[AW-1:0]] <= TXdata;
    if (rxPush) rxMem[rxWp[AW-1:0]] <= rxShift;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      txWp <= '0;
      txRp <= '0;
      rxWp <= '0;
      rxRp <= '0;
      RXdata <= '0;
    end else begin
      if (txPush) txWp <= txWp + 1'b1;
      if (txPop) txRp <= txRp + 1'b1;
      if (rxPush) rxWp <= rxWp + 1'b1;
      if (rxPop) rxRp <= rxRp + 1'b1;
      if (rxPop) RXdata <= rxMem[rxRp[AW-1:0]];
    end
  // reloadPend marks that the next SCK fall starts a new TX word instead of shifting
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      txShift <= '0;
      rxShift <= '0;
      bitCnt <= '0;
      reloadPend <= 1'b0;
      wordDone <= 1'b0;
      doneTransaction <= 1'b0;
      overrun <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (txLoad) txShift <= TXFIFOempty ? '0 : txMem[txRp[AW-1:0]];
      else if (active & sckFall) txShift <= {txShift[WIDTH-2:0], 1'b0};
      if (active & sckRise) rxShift <= {rxShift[WIDTH-2:0], mosiSync[1]};
      if (active & csRise) bitCnt <= '0;
      else if (active & sckRise) bitCnt <= wrapRise ? '0 : bitCnt + 1'b1;
      reloadPend <= active & ~csRise & (wrapRise | (reloadPend & ~sckFall));
      wordDone <= wrapRise;
      doneTransaction <= active & csRise;
      overrun <= (wordDone & ~rxPush) | (overrun & ~clearErr);
      underrun <= (txLoad & TXFIFOempty) | (underrun & ~clearErr);
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed mode-0 master stimulus against spi_slave with hand-computed expectations.
module tb_spi_slave;
  localparam int HALF = 6;
  logic clk = 1'b0, rst_n = 1'b0;
  logic CS_n = 1'b1, SCK = 1'b0, MOSI = 1'b0, MISO;
  logic [7:0] TXdata = '0, RXdata;
  logic writeEn = 1'b0, readEn = 1'b0, clearErr = 1'b0;
  logic TXFIFOempty, TXFIFOfull, RXFIFOempty, RXFIFOfull;
  logic wordDone, doneTransaction, overrun, underrun;
  int total = 0, bad = 0, wdCnt = 0, dtCnt = 0, wd0, dt0;
  logic [7:0] rx, v;

  spi_slave #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .CS_n(CS_n), .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
    .TXdata(TXdata), .writeEn(writeEn), .TXFIFOempty(TXFIFOempty), .TXFIFOfull(TXFIFOfull),
    .RXdata(RXdata), .readEn(readEn), .RXFIFOempty(RXFIFOempty), .RXFIFOfull(RXFIFOfull),
    .wordDone(wordDone), .doneTransaction(doneTransaction), .overrun(overrun),
    .underrun(underrun), .clearErr(clearErr)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wordDone) wdCnt++;
    if (doneTransaction) dtCnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushTx(input logic [7:0] d);
    @(negedge clk);
    TXdata = d;
    writeEn = 1'b1;
    @(negedge clk);
    writeEn = 1'b0;
  endtask

  task automatic popRx(output logic [7:0] d);
    @(negedge clk);
    readEn = 1'b1;
    @(negedge clk);
    readEn = 1'b0;
    d = RXdata;
  endtask

  task automatic pulseClr();
    @(negedge clk);
    clearErr = 1'b1;
    @(negedge clk);
    clearErr = 1'b0;
  endtask

  task automatic csLow();
    @(negedge clk);
    CS_n = 1'b0;
    waitClk(8);
  endtask

  task automatic csHigh();
    waitClk(HALF);
    CS_n = 1'b1;
    waitClk(8);
  endtask

  // sends the top n bits of d MSB first, capturing MISO at each SCK rise
  task automatic spiXfer(input logic [7:0] d, input int n, output logic [7:0] r);
    r = '0;
    for (int i = 7; i >= 8 - n; i--) begin
      MOSI = d[i];
      waitClk(HALF);
      SCK = 1'b1;
      r[i] = MISO;
      waitClk(HALF);
      SCK = 1'b0;
    end
  endtask

  initial begin
    waitClk(3);
    chk("reset_outs", {MISO, RXdata, wordDone, doneTransaction, overrun, underrun},
        {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_flags", {TXFIFOempty, RXFIFOempty, TXFIFOfull, RXFIFOfull}, 4'b1100);
    rst_n = 1'b1;
    waitClk(4);

    pushTx(8'hA5);
    chk("tx_not_empty", TXFIFOempty, 1'b0);
    wd0 = wdCnt;
    dt0 = dtCnt;
    csLow();
    spiXfer(8'h3C, 8, rx);
    csHigh();
    chk("single_miso", rx, 8'hA5);
    chk("single_wd", wdCnt - wd0, 1);
    chk("single_dt", dtCnt - dt0, 1);
    chk("single_rx_ne", RXFIFOempty, 1'b0);
    popRx(v);
    chk("single_rxdata", v, 8'h3C);
    chk("single_rx_empty", RXFIFOempty, 1'b1);
    pulseClr();

    for (int i = 0; i < 4; i++) pushTx(8'h10 + 8'(i));
    csLow();
    for (int i = 0; i < 4; i++) begin
      spiXfer(8'(i), 8, rx);
      chk("multi_miso", rx, 8'h10 + 8'(i));
    end
    csHigh();
    chk("multi_tx_empty", TXFIFOempty, 1'b1);
    for (int i = 0; i < 4; i++) begin
      popRx(v);
      chk("multi_rxdata", v, 8'(i));
    end
    pulseClr();
    chk("clear_under0", underrun, 1'b0);

    csLow();
    spiXfer(8'h55, 8, rx);
    csHigh();
    chk("under_miso", rx, 8'h00);
    chk("under_flag", underrun, 1'b1);
    pulseClr();
    chk("under_clear", underrun, 1'b0);
    popRx(v);
    chk("under_rxdata", v, 8'h55);

    csLow();
    for (int i = 0; i < 17; i++) spiXfer(8'h40 + 8'(i), 8, rx);
    csHigh();
    chk("ovr_full", RXFIFOfull, 1'b1);
    chk("ovr_flag", overrun, 1'b1);
    popRx(v);
    chk("ovr_first", v, 8'h40);
    chk("ovr_not_full", RXFIFOfull, 1'b0);
    for (int i = 1; i < 16; i++) popRx(v);
    chk("ovr_last", v, 8'h4F);
    chk("ovr_drained", RXFIFOempty, 1'b1);
    pulseClr();
    chk("ovr_clear", overrun, 1'b0);

    dt0 = dtCnt;
    wd0 = wdCnt;
    csLow();
    spiXfer(8'hFF, 5, rx);
    csHigh();
    chk("part_no_push", RXFIFOempty, 1'b1);
    chk("part_no_wd", wdCnt - wd0, 0);
    chk("part_dt", dtCnt - dt0, 1);
    csLow();
    spiXfer(8'h96, 8, rx);
    csHigh();
    popRx(v);
    chk("part_next_word", v, 8'h96);

    pushTx(8'hFF);
    pushTx(8'hFF);
    csLow();
    spiXfer(8'h81, 3, rx);
    chk("rst_pre_miso", MISO, 1'b1);
    chk("rst_pre_under", underrun, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {MISO, RXdata, wordDone, doneTransaction, overrun, underrun},
        {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("rst_async_flags", {TXFIFOempty, RXFIFOempty, TXFIFOfull, RXFIFOfull}, 4'b1100);
    CS_n = 1'b1;
    waitClk(4);
    rst_n = 1'b1;
    waitClk(4);
    pushTx(8'h5A);
    csLow();
    spiXfer(8'hC3, 8, rx);
    csHigh();
    chk("post_rst_miso", rx, 8'h5A);
    popRx(v);
    chk("post_rst_rxdata", v, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
